// File: rtl/div_issue_pkg.sv
//------------------------------------------------------------------------------
// Module  : div_issue_pkg
// Brief   : Shared CPU divide-issue types, default operand width, result layout.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_issue_pkg;

  localparam int DIV_WIDTH_DEFAULT = 24;
  localparam int RES_QUOT_LSB      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } div_state_e;

  // The remainder sits directly above the quotient in the divider result.
  function automatic int res_rem_lsb(input int width);
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_issue.sv
//------------------------------------------------------------------------------
// Module  : div_issue
// Brief   : Issues EX-stage divides to an external divider, stalls the pipe,
//           handles flush/timeout abort. Optional DIV_ZERO_TRAP_EN bypass.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_issue
  import div_issue_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  input  logic               req_signed_i,
  input  logic [WIDTH-1:0]   req_dividend_i,
  input  logic [WIDTH-1:0]   req_divisor_i,
  input  logic               flush_i,
  output logic               stall_req_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic               err_o,
  output logic               div_zero_o,
  output logic               div_start_o,
  output logic               div_annul_o,
  output logic               div_signed_o,
  output logic [WIDTH-1:0]   div_op1_o,
  output logic [WIDTH-1:0]   div_op2_o,
  input  logic [2*WIDTH-1:0] div_result_i,
  input  logic               div_ready_i
);

  localparam int                c_cnt_w      = $clog2(TIMEOUT + 1);
  localparam int                c_rem_lsb    = res_rem_lsb(WIDTH);
  localparam logic [c_cnt_w-1:0] c_timeout_m1 = c_cnt_w'(TIMEOUT - 1);

  div_state_e           r_state;
  div_state_e           w_next_state;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_signed;
  logic [WIDTH-1:0]     r_op1;
  logic [WIDTH-1:0]     r_op2;
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_rem;
  logic                 w_accept;
  logic                 w_zero_div;
  logic                 w_capture;
  logic                 w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && req_valid_i && !flush_i;
  assign w_capture = (r_state == ST_BUSY) && div_ready_i && !flush_i;
  assign w_timeout = (r_state == ST_BUSY) && !div_ready_i && !flush_i &&
                     (r_count == c_timeout_m1);

`ifdef DIV_ZERO_TRAP_EN
  logic r_zero;

  assign w_zero_div = (req_divisor_i == '0);
  assign div_zero_o = (r_state == ST_DONE) && r_zero && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_zero <= 1'b0;
    else if (w_accept) r_zero <= w_zero_div;
  end
`else
  assign w_zero_div = 1'b0;
  assign div_zero_o = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_zero_div ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        // Flush wins over a same-cycle result: the instruction is gone.
        if (flush_i)          w_next_state = ST_ABORT;
        else if (div_ready_i) w_next_state = ST_DONE;
        else if (w_timeout)   w_next_state = ST_ABORT;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      ST_ABORT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_count  <= '0;
        r_signed <= req_signed_i;
        r_op1    <= req_dividend_i;
        r_op2    <= req_divisor_i;
      end else if (r_state == ST_BUSY) begin
        r_count <= r_count + c_cnt_w'(1);
      end
      if (w_accept && w_zero_div) begin
        r_quot <= '1;
        r_rem  <= req_dividend_i;
      end else if (w_capture) begin
        r_quot <= div_result_i[RES_QUOT_LSB +: WIDTH];
        r_rem  <= div_result_i[c_rem_lsb +: WIDTH];
      end
    end
  end

  // Control strobes decode straight from the state register so reset clears them at once.
  assign div_start_o  = (r_state == ST_BUSY);
  assign div_annul_o  = (r_state == ST_ABORT);
  assign done_o       = (r_state == ST_DONE) && !flush_i;
  assign err_o        = w_timeout;
  assign stall_req_o  = w_accept || (r_state == ST_BUSY) || (r_state == ST_ABORT);
  assign quot_o       = r_quot;
  assign rem_o        = r_rem;
  assign div_signed_o = r_signed;
  assign div_op1_o    = r_op1;
  assign div_op2_o    = r_op2;

endmodule

`default_nettype wire

// File: tb/tb_div_issue.sv
//------------------------------------------------------------------------------
// Module  : tb_div_issue
// Brief   : Directed bench for div_issue with an inline programmable-latency
//           divider stub. Zero-divide expectations follow DIV_ZERO_TRAP_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_signed_i = 1'b0;
  logic [23:0] req_dividend_i = '0;
  logic [23:0] req_divisor_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_req_o, done_o, err_o, div_zero_o;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [23:0] quot_o, rem_o, div_op1_o, div_op2_o;
  logic [47:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;

  div_issue #(.WIDTH(24), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_signed_i(req_signed_i),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .done_o(done_o),
    .quot_o(quot_o), .rem_o(rem_o), .err_o(err_o), .div_zero_o(div_zero_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int   stall_n, done_n, start_n, annul_n, err_n, zero_n, err_at;
  logic annul_bad, sgn_ok, ops_ok, hung;

  // lat: BUSY cycle in which the stub raises ready (0 = never).
  // flush_at: BUSY cycle in which flush_i is raised (0 = never).
  task automatic do_div(input logic sgn, input logic [23:0] a, input logic [23:0] b,
                        input int lat, input logic [47:0] res, input int flush_at,
                        input logic hold);
    int busy_n;
    busy_n = 0;
    stall_n = 0; done_n = 0; start_n = 0; annul_n = 0; err_n = 0; zero_n = 0;
    err_at = -1; annul_bad = 1'b0; sgn_ok = 1'b1; ops_ok = 1'b1; hung = 1'b1;
    div_result_i = res;
    @(negedge clk);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 0) begin
        req_valid_i = 1'b1; req_signed_i = sgn;
        req_dividend_i = a; req_divisor_i = b;
      end else begin
        req_valid_i = hold && (done_n == 0);
        req_signed_i = ~sgn; req_dividend_i = a ^ 24'h00_5A5A; req_divisor_i = b + 24'd3;
      end
      if (div_start_o) busy_n++;
      div_ready_i = div_start_o && (busy_n == lat);
      flush_i     = div_start_o && (busy_n == flush_at);
      #1;
      if (stall_req_o) stall_n++;
      if (done_o) done_n++;
      if (div_zero_o) zero_n++;
      if (div_annul_o) annul_n++;
      if (div_annul_o && div_start_o) annul_bad = 1'b1;
      if (err_o) begin err_n++; err_at = busy_n; end
      if (div_start_o) begin
        start_n++;
        if (div_signed_o !== sgn) sgn_ok = 1'b0;
        if (div_op1_o !== a || div_op2_o !== b) ops_ok = 1'b0;
      end
      if (cyc > 0 && !stall_req_o && !done_o && !div_annul_o && !div_start_o) begin
        hung = 1'b0;
        break;
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0; div_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({stall_req_o, done_o, err_o, div_zero_o, div_start_o, div_annul_o, div_signed_o} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b exp 0000000",
        {stall_req_o, done_o, err_o, div_zero_o, div_start_o, div_annul_o, div_signed_o});
    end
    n_cmp++;
    if ({quot_o, rem_o, div_op1_o, div_op2_o} !== 96'b0) begin
      n_bad++; $display("FAIL reset_data: got %h exp 0", {quot_o, rem_o, div_op1_o, div_op2_o});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    // 703/703, latency 26, request held while stalled with changing operands.
    do_div(1'b0, 24'd703, 24'd703, 26, {24'd0, 24'd1}, 0, 1'b1);
    n_cmp++;
    if (hung !== 1'b0) begin n_bad++; $display("FAIL unsigned_hang: got %b exp 0", hung); end
    n_cmp++;
    if (stall_n !== 27) begin n_bad++; $display("FAIL unsigned_stall: got %0d exp 27", stall_n); end
    n_cmp++;
    if (done_n !== 1) begin n_bad++; $display("FAIL unsigned_done: got %0d exp 1", done_n); end
    n_cmp++;
    if (start_n !== 26) begin n_bad++; $display("FAIL unsigned_start: got %0d exp 26", start_n); end
    n_cmp++;
    if (quot_o !== 24'd1 || rem_o !== 24'd0) begin
      n_bad++; $display("FAIL unsigned_result: got q=%0h r=%0h exp q=1 r=0", quot_o, rem_o);
    end
    n_cmp++;
    if (ops_ok !== 1'b1 || sgn_ok !== 1'b1) begin
      n_bad++; $display("FAIL unsigned_ops_stable: got ops=%b sgn=%b exp 1 1", ops_ok, sgn_ok);
    end
  endtask

  task automatic test_signed;
    do_div(1'b1, 24'hFFFFF9, 24'd2, 5, {24'hFFFFFF, 24'hFFFFFD}, 0, 1'b0);
    n_cmp++;
    if (sgn_ok !== 1'b1 || ops_ok !== 1'b1) begin
      n_bad++; $display("FAIL signed_sel: got sgn=%b ops=%b exp 1 1", sgn_ok, ops_ok);
    end
    n_cmp++;
    if (quot_o !== 24'hFFFFFD || rem_o !== 24'hFFFFFF) begin
      n_bad++; $display("FAIL signed_result: got q=%h r=%h exp q=fffffd r=ffffff", quot_o, rem_o);
    end
    n_cmp++;
    if (stall_n !== 6 || done_n !== 1) begin
      n_bad++; $display("FAIL signed_timing: got stall=%0d done=%0d exp 6 1", stall_n, done_n);
    end
  endtask

  task automatic test_flush;
    // Ready arrives in the flush cycle too; flush must still win.
    do_div(1'b0, 24'd50, 24'd7, 5, {24'd1, 24'd7}, 5, 1'b0);
    n_cmp++;
    if (annul_n !== 1 || annul_bad !== 1'b0) begin
      n_bad++; $display("FAIL flush_annul: got n=%0d with_start=%b exp 1 0", annul_n, annul_bad);
    end
    n_cmp++;
    if (done_n !== 0 || hung !== 1'b0) begin
      n_bad++; $display("FAIL flush_done: got done=%0d hung=%b exp 0 0", done_n, hung);
    end
    n_cmp++;
    if (stall_n !== 7 || start_n !== 5) begin
      n_bad++; $display("FAIL flush_timing: got stall=%0d start=%0d exp 7 5", stall_n, start_n);
    end
    n_cmp++;
    if (quot_o !== 24'hFFFFFD || rem_o !== 24'hFFFFFF) begin
      n_bad++; $display("FAIL flush_hold: got q=%h r=%h exp fffffd ffffff", quot_o, rem_o);
    end
  endtask

  task automatic test_timeout;
    do_div(1'b0, 24'd9, 24'd3, 0, 48'd0, 0, 1'b0);
    n_cmp++;
    if (err_n !== 1 || err_at !== 64) begin
      n_bad++; $display("FAIL timeout_err: got n=%0d at=%0d exp 1 64", err_n, err_at);
    end
    n_cmp++;
    if (annul_n !== 1 || done_n !== 0) begin
      n_bad++; $display("FAIL timeout_annul: got annul=%0d done=%0d exp 1 0", annul_n, done_n);
    end
    n_cmp++;
    if (stall_n !== 66 || start_n !== 64 || hung !== 1'b0) begin
      n_bad++; $display("FAIL timeout_timing: got stall=%0d start=%0d hung=%b exp 66 64 0",
                        stall_n, start_n, hung);
    end
  endtask

  task automatic test_zero_div;
    do_div(1'b0, 24'd100, 24'd0, 3, {24'd7, 24'd9}, 0, 1'b0);
`ifdef DIV_ZERO_TRAP_EN
    n_cmp++;
    if (start_n !== 0 || stall_n !== 1) begin
      n_bad++; $display("FAIL zero_bypass: got start=%0d stall=%0d exp 0 1", start_n, stall_n);
    end
    n_cmp++;
    if (zero_n !== 1 || done_n !== 1) begin
      n_bad++; $display("FAIL zero_strobe: got zero=%0d done=%0d exp 1 1", zero_n, done_n);
    end
    n_cmp++;
    if (quot_o !== 24'hFFFFFF || rem_o !== 24'd100) begin
      n_bad++; $display("FAIL zero_result: got q=%h r=%0d exp ffffff 100", quot_o, rem_o);
    end
`else
    n_cmp++;
    if (start_n !== 3 || zero_n !== 0) begin
      n_bad++; $display("FAIL zero_issue: got start=%0d zero=%0d exp 3 0", start_n, zero_n);
    end
    n_cmp++;
    if (done_n !== 1 || quot_o !== 24'd9 || rem_o !== 24'd7) begin
      n_bad++; $display("FAIL zero_result: got done=%0d q=%0d r=%0d exp 1 9 7", done_n, quot_o, rem_o);
    end
`endif
  endtask

  task automatic test_rst_mid_busy;
    @(negedge clk);
    req_valid_i = 1'b1; req_signed_i = 1'b1;
    req_dividend_i = 24'h123456; req_divisor_i = 24'h000011;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (div_start_o !== 1'b1) begin n_bad++; $display("FAIL rst_busy_pre: got %b exp 1", div_start_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({stall_req_o, done_o, err_o, div_zero_o, div_start_o, div_annul_o, div_signed_o,
         quot_o, rem_o, div_op1_o, div_op2_o} !== 103'b0) begin
      n_bad++; $display("FAIL rst_async: got start=%b stall=%b sgn=%b q=%h op1=%h exp all 0",
                        div_start_o, stall_req_o, div_signed_o, quot_o, div_op1_o);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (div_annul_o !== 1'b0) begin n_bad++; $display("FAIL rst_no_annul: got %b exp 0", div_annul_o); end
    rst = 1'b0;
    do_div(1'b0, 24'd1000, 24'd7, 4, {24'd6, 24'd142}, 0, 1'b0);
    n_cmp++;
    if (done_n !== 1 || quot_o !== 24'd142 || rem_o !== 24'd6 || stall_n !== 5) begin
      n_bad++; $display("FAIL rst_recover: got done=%0d q=%0d r=%0d stall=%0d exp 1 142 6 5",
                        done_n, quot_o, rem_o, stall_n);
    end
  endtask

  task automatic test_back_to_back;
    do_div(1'b0, 24'd20, 24'd6, 1, {24'd2, 24'd3}, 0, 1'b0);
    do_div(1'b1, 24'hFFFFEC, 24'd6, 2, {24'hFFFFFE, 24'hFFFFFD}, 0, 1'b0);
    n_cmp++;
    if (quot_o !== 24'hFFFFFD || rem_o !== 24'hFFFFFE || stall_n !== 3 || done_n !== 1) begin
      n_bad++; $display("FAIL back_to_back: got q=%h r=%h stall=%0d done=%0d exp fffffd fffffe 3 1",
                        quot_o, rem_o, stall_n, done_n);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_timeout();
    test_zero_div();
    test_rst_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
